// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the sequential shifter: operation codes and FSM states.
// Imported by the shifter and by anything that drives its op port.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage : seq_shifter_pkg

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves the captured operand one bit per cycle for shamt
// cycles, then pulses done for one cycle with the registered result.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Single-bit move; SRA copies the current MSB, which is the operand's sign
  // because every prior step preserved it.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                             input op_e               o);
    logic [WIDTH-1:0] r;
    r = v;
    unique case (o)
      OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        // flush is meaningless here, so a simultaneous start still wins
        if (start) begin
          op_d     = op_e'(op);
          result_d = operand;
          count_d  = shamt;
          state_d  = (shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end

      ST_SHIFT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          result_d = step1(result_q, op_q);
          count_d  = count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all of them
      // update together from values sampled before the edge.
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule : seq_shifter

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed corner cases plus random
// operations compared against an arithmetic reference of the shift.
module tb_seq_shifter;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int BUDGET = 40;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   shamt;
  logic             flush;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .flush   (flush),
    .ready   (ready),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole shift in one arithmetic step.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                             input logic [WIDTH-1:0] v,
                                             input int s);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (o)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b10:   return WIDTH'(sv >>> s);
      default: return v;
    endcase
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble inputs while it runs, and check latency,
  // result, pulse width and return to IDLE.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [WIDTH-1:0] v, input int s,
                        input logic flush_at_start);
    int k;
    logic [WIDTH-1:0] exp;
    exp     = model(o, v, s);
    start   = 1'b1;
    op      = o;
    operand = v;
    shamt   = SHW'(s);
    flush   = flush_at_start;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check({tag, "_ready_busy"}, WIDTH'(ready), WIDTH'(0));
    k = 0;
    while (!done && k < BUDGET) begin
      start   = 1'($urandom_range(0, 1));
      op      = 2'($urandom);
      operand = $urandom;
      shamt   = SHW'($urandom);
      tick();
      k++;
    end
    start = 1'b0;
    check({tag, "_latency"}, WIDTH'(k), WIDTH'(s));
    check({tag, "_result"}, result, exp);
    tick();
    check({tag, "_done_width"}, WIDTH'(done), WIDTH'(0));
    check({tag, "_ready_back"}, WIDTH'(ready), WIDTH'(1));
    check({tag, "_result_hold"}, result, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    operand = '0;
    shamt   = '0;
    flush   = 1'b0;
    #12;
    check("rst_ready", WIDTH'(ready), WIDTH'(1));
    check("rst_done", WIDTH'(done), WIDTH'(0));
    check("rst_result", result, '0);
    rst_n = 1'b1;
    tick();
    check("idle_no_done", WIDTH'(done), WIDTH'(0));

    run_op("sra4", 2'b10, 32'hAAAA_FFFF, 4, 1'b0);
    check("sra4_golden", model(2'b10, 32'hAAAA_FFFF, 4), 32'hFAAA_AFFF);
    run_op("srl4", 2'b01, 32'hAAAA_FFFF, 4, 1'b0);
    run_op("sll31", 2'b00, 32'h0000_0001, 31, 1'b0);
    run_op("srl31", 2'b01, 32'h8000_0000, 31, 1'b0);
    run_op("sra31", 2'b10, 32'h8000_0000, 31, 1'b0);
    for (int o = 0; o < 4; o++) begin
      run_op($sformatf("zero_op%0d", o), 2'(o), 32'h1234_5678, 0, 1'b0);
    end
    run_op("rsv7", 2'b11, 32'hDEAD_BEEF, 7, 1'b0);
    run_op("flush_start_idle", 2'b01, 32'hF0F0_F0F0, 3, 1'b1);

    // Flush on the fifth SHIFT cycle: four shifts done, then abort.
    start = 1'b1; op = 2'b01; operand = 32'hFFFF_FFFF; shamt = SHW'(16);
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("flush_busy", WIDTH'(ready), WIDTH'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", WIDTH'(ready), WIDTH'(1));
    check("flush_done", WIDTH'(done), WIDTH'(0));
    check("flush_result", result, 32'h0FFF_FFFF);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (done) seen++;
      end
      check("flush_no_done", WIDTH'(seen), WIDTH'(0));
    end
    run_op("after_flush", 2'b00, 32'h0000_00FF, 8, 1'b0);

    // Async reset in the middle of a long shift with start held high.
    start = 1'b1; op = 2'b00; operand = 32'h0000_0003; shamt = SHW'(20);
    tick();
    repeat (5) tick();
    check("held_start_busy", WIDTH'(ready), WIDTH'(0));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", WIDTH'(ready), WIDTH'(1));
    check("midrst_done", WIDTH'(done), WIDTH'(0));
    check("midrst_result", result, '0);
    #1 rst_n = 1'b1;
    start = 1'b0;
    run_op("after_rst", 2'b10, 32'h8765_4321, 12, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op($sformatf("rand%0d", n), 2'($urandom), $urandom,
             int'($urandom_range(0, WIDTH - 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_shifter
